// File: rtl/ldst_address_buffer.sv
// In-order load/store address buffer: holds lw/sw entries in program order,
// resolves base/store-data operands from the CDB and computes effective addresses.
module ldst_address_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ROBEN_W = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               InstQ_VALID_Inst,
    input  logic [11:0]        Decoded_opcode,
    input  logic [ROBEN_W-1:0] Decoded_ROBEN,
    input  logic [4:0]         Decoded_Rd,
    input  logic [ROBEN_W-1:0] ROBEN1,
    input  logic [ROBEN_W-1:0] ROBEN2,
    input  logic [DATA_W-1:0]  ROBEN1_VAL,
    input  logic [DATA_W-1:0]  ROBEN2_VAL,
    input  logic [DATA_W-1:0]  Immediate,
    input  logic               CDB_VALID,
    input  logic [ROBEN_W-1:0] CDB_ROBEN,
    input  logic [DATA_W-1:0]  CDB_VAL,
    input  logic               FLUSH,
    input  logic               MEM_READY,
    output logic               LdStB_FULL,
    output logic               LdStB_EMPTY,
    output logic               MEM_VALID,
    output logic [ROBEN_W-1:0] MEM_ROBEN,
    output logic [4:0]         MEM_Rd,
    output logic [11:0]        MEM_opcode,
    output logic [DATA_W-1:0]  MEM_EA,
    output logic [DATA_W-1:0]  MEM_WDATA
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [11:0] OP_LW = 12'h8C0;
    localparam logic [11:0] OP_SW = 12'hAC0;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [DEPTH-1:0]   e_valid;
    logic [DEPTH-1:0]   e_ea_valid;
    logic [11:0]        e_opcode [DEPTH];
    logic [ROBEN_W-1:0] e_roben  [DEPTH];
    logic [4:0]         e_rd     [DEPTH];
    logic [ROBEN_W-1:0] e_q1     [DEPTH];
    logic [ROBEN_W-1:0] e_q2     [DEPTH];
    logic [DATA_W-1:0]  e_v1     [DEPTH];
    logic [DATA_W-1:0]  e_v2     [DEPTH];
    logic [DATA_W-1:0]  e_imm    [DEPTH];
    logic [DATA_W-1:0]  e_ea     [DEPTH];

    logic               is_ldst_c;
    logic               head_ready_c;
    logic               retire_c;
    logic               alloc_c;
    logic               byp1_c;
    logic               byp2_c;
    logic [ROBEN_W-1:0] q1_in_c;
    logic [ROBEN_W-1:0] q2_in_c;
    logic [DATA_W-1:0]  v1_in_c;
    logic [DATA_W-1:0]  v2_in_c;

    // Head issue condition and allocation/retire decisions
    always_comb begin
        is_ldst_c    = (Decoded_opcode == OP_LW) || (Decoded_opcode == OP_SW);
        head_ready_c = e_valid[head] && e_ea_valid[head] &&
                       ((e_opcode[head] != OP_SW) || (e_q2[head] == '0));
        retire_c     = head_ready_c && MEM_READY;
        // A full buffer still accepts when the head frees its slot this cycle
        alloc_c      = InstQ_VALID_Inst && is_ldst_c && (!LdStB_FULL || retire_c);
    end

    // Same-cycle CDB bypass for incoming operands
    always_comb begin
        byp1_c  = CDB_VALID && (ROBEN1 != '0) && (ROBEN1 == CDB_ROBEN);
        byp2_c  = CDB_VALID && (ROBEN2 != '0) && (ROBEN2 == CDB_ROBEN);
        q1_in_c = byp1_c ? '0 : ROBEN1;
        q2_in_c = byp2_c ? '0 : ROBEN2;
        v1_in_c = byp1_c ? CDB_VAL : ROBEN1_VAL;
        v2_in_c = byp2_c ? CDB_VAL : ROBEN2_VAL;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (FLUSH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_c) begin
                tail <= tail + PTR_W'(1);
            end
            if (retire_c) begin
                head <= head + PTR_W'(1);
            end
            if (alloc_c && !retire_c) begin
                count <= count + CNT_W'(1);
            end else if (!alloc_c && retire_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage: CDB capture, EA generation, retire, then allocation wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid    <= '0;
            e_ea_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_opcode[i] <= '0;
                e_roben[i]  <= '0;
                e_rd[i]     <= '0;
                e_q1[i]     <= '0;
                e_q2[i]     <= '0;
                e_v1[i]     <= '0;
                e_v2[i]     <= '0;
                e_imm[i]    <= '0;
                e_ea[i]     <= '0;
            end
        end else if (FLUSH) begin
            e_valid    <= '0;
            e_ea_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && CDB_VALID && (e_q1[i] != '0) && (e_q1[i] == CDB_ROBEN)) begin
                    e_v1[i] <= CDB_VAL;
                    e_q1[i] <= '0;
                end
                if (e_valid[i] && CDB_VALID && (e_q2[i] != '0) && (e_q2[i] == CDB_ROBEN)) begin
                    e_v2[i] <= CDB_VAL;
                    e_q2[i] <= '0;
                end
                // Uses the registered V1, so EA lags any V1 capture by a cycle
                if (e_valid[i] && (e_q1[i] == '0) && !e_ea_valid[i]) begin
                    e_ea[i]       <= e_v1[i] + e_imm[i];
                    e_ea_valid[i] <= 1'b1;
                end
                if (retire_c && (head == PTR_W'(i))) begin
                    e_valid[i]    <= 1'b0;
                    e_ea_valid[i] <= 1'b0;
                end
                if (alloc_c && (tail == PTR_W'(i))) begin
                    e_valid[i]    <= 1'b1;
                    e_ea_valid[i] <= 1'b0;
                    e_opcode[i]   <= Decoded_opcode;
                    e_roben[i]    <= Decoded_ROBEN;
                    e_rd[i]       <= Decoded_Rd;
                    e_q1[i]       <= q1_in_c;
                    e_q2[i]       <= q2_in_c;
                    e_v1[i]       <= v1_in_c;
                    e_v2[i]       <= v2_in_c;
                    e_imm[i]      <= Immediate;
                end
            end
        end
    end

    assign LdStB_FULL  = (count == CNT_W'(DEPTH));
    assign LdStB_EMPTY = (count == '0);
    assign MEM_VALID   = head_ready_c;
    assign MEM_ROBEN   = e_roben[head];
    assign MEM_Rd      = e_rd[head];
    assign MEM_opcode  = e_opcode[head];
    assign MEM_EA      = e_ea[head];
    assign MEM_WDATA   = e_v2[head];

endmodule
